// File: rtl/frac_search_pkg.sv
// Shared types and constants for the frac_search sequencer.
// Optional abort support is selected with FRAC_SEARCH_CTRL_ABORT_EN.
package frac_search_pkg;

    localparam int PIX_W        = 64;
    localparam int MV_W         = 3;
    localparam int DEFAULT_ROWS = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FETCH,
        WAIT_RES
    } state_t;

endpackage

// File: rtl/frac_row_fetch.sv
// Row fetch engine: issues row reads, registers returned data
// and presents one row per cycle to the datapath.
module frac_row_fetch
    import frac_search_pkg::*;
#(
    parameter int ROWS   = DEFAULT_ROWS,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              flush,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic [ADDR_W-1:0] base_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  filt_data,
    input  logic [PIX_W-1:0]  ref_data,
    output logic [PIX_W-1:0]  filter_pix,
    output logic [PIX_W-1:0]  ref_pix,
    output logic              input_ready,
    output logic              last_presented
);

    localparam int CW = $clog2(ROWS + 1);

    logic [CW-1:0]     issue_cnt;
    logic [CW-1:0]     present_cnt;
    logic [ADDR_W-1:0] base;
    logic              ret_vld;

    assign rd_en = fetch_en && !stall && (issue_cnt != CW'(ROWS));
    assign rd_addr = rd_en ? base + ADDR_W'(issue_cnt) : '0;
    assign last_presented = input_ready &&
                            (present_cnt == CW'(ROWS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_cnt   <= '0;
            present_cnt <= '0;
            base        <= '0;
            ret_vld     <= 1'b0;
            input_ready <= 1'b0;
            filter_pix  <= '0;
            ref_pix     <= '0;
        end else begin
            if (init) begin
                base        <= base_in;
                issue_cnt   <= '0;
                present_cnt <= '0;
            end else begin
                if (rd_en)
                    issue_cnt <= issue_cnt + CW'(1);
                if (input_ready)
                    present_cnt <= present_cnt + CW'(1);
            end
            // Flush drops any read still in the return pipe.
            if (flush) begin
                ret_vld     <= 1'b0;
                input_ready <= 1'b0;
            end else begin
                ret_vld     <= rd_en;
                input_ready <= ret_vld;
                if (ret_vld) begin
                    filter_pix <= filt_data;
                    ref_pix    <= ref_data;
                end
            end
        end
    end

endmodule

// File: rtl/frac_search_ctrl.sv
// Block-level sequencer for the frac_search datapath.
// Define FRAC_SEARCH_CTRL_ABORT_EN to add the abort input.
module frac_search_ctrl
    import frac_search_pkg::*;
#(
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int RESULT_LAT = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] blk_addr,
`ifdef FRAC_SEARCH_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [MV_W-1:0]   mv_x,
    output logic [MV_W-1:0]   mv_y,
    input  logic              stall,
    output logic              filt_rd_en,
    output logic              ref_rd_en,
    output logic [ADDR_W-1:0] filt_rd_addr,
    output logic [ADDR_W-1:0] ref_rd_addr,
    input  logic [PIX_W-1:0]  filt_rd_data,
    input  logic [PIX_W-1:0]  ref_rd_data,
    output logic [PIX_W-1:0]  fs_filter_pix,
    output logic [PIX_W-1:0]  fs_ref_pix,
    output logic              fs_input_ready,
    output logic              fs_clear,
    input  logic [MV_W-1:0]   fs_mvx,
    input  logic [MV_W-1:0]   fs_mvy
);

    localparam int WW = $clog2(RESULT_LAT + 1);

    state_t            state;
    state_t            state_d;
    logic [WW-1:0]     wait_cnt;
    logic              wait_last;
    logic              accept;
    logic              capture;
    logic              abort_now;
    logic              abort_clr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_presented;

    assign busy      = (state != IDLE);
    assign wait_last = (wait_cnt == WW'(RESULT_LAT - 1));

`ifdef FRAC_SEARCH_CTRL_ABORT_EN
    assign abort_now = abort && busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            abort_clr <= 1'b0;
        else
            abort_clr <= abort_now;
    end
`else
    assign abort_now = 1'b0;
    assign abort_clr = 1'b0;
`endif

    assign fs_clear     = (state == CLEAR) || abort_clr;
    assign filt_rd_en   = rd_en;
    assign ref_rd_en    = rd_en;
    assign filt_rd_addr = rd_addr;
    assign ref_rd_addr  = rd_addr;

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR:
                state_d = FETCH;
            FETCH: begin
                if (last_presented)
                    state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (wait_last) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default:
                state_d = IDLE;
        endcase
        if (abort_now) begin
            state_d = IDLE;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            done     <= 1'b0;
            mv_x     <= '0;
            mv_y     <= '0;
        end else begin
            state <= state_d;
            if (state == WAIT_RES && !wait_last)
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
            done <= capture;
            if (capture) begin
                mv_x <= fs_mvx;
                mv_y <= fs_mvy;
            end
        end
    end

    frac_row_fetch #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk            (clk),
        .reset          (reset),
        .init           (accept),
        .flush          (abort_now),
        .fetch_en       ((state == FETCH) && !abort_now),
        .stall          (stall),
        .base_in        (blk_addr),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .filt_data      (filt_rd_data),
        .ref_data       (ref_rd_data),
        .filter_pix     (fs_filter_pix),
        .ref_pix        (fs_ref_pix),
        .input_ready    (fs_input_ready),
        .last_presented (last_presented)
    );

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Self-checking bench for frac_search_ctrl: vector table plus
// scoreboard queues of expected addresses and presented rows.
module tb_frac_search_ctrl;
    import frac_search_pkg::*;

    localparam int ROWS = 8;
    localparam int LAT  = 4;
    localparam int AW   = 8;
    localparam int SLEN = ROWS + LAT + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] blk_addr = '0;
`ifdef FRAC_SEARCH_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif
    logic          busy, done;
    logic [2:0]    mv_x, mv_y;
    logic          filt_rd_en, ref_rd_en;
    logic [AW-1:0] filt_rd_addr, ref_rd_addr;
    logic [63:0]   filt_rd_data = '0;
    logic [63:0]   ref_rd_data = '0;
    logic [63:0]   fs_filter_pix, fs_ref_pix;
    logic          fs_input_ready, fs_clear;
    logic [2:0]    fs_mvx = '0;
    logic [2:0]    fs_mvy = '0;

    frac_search_ctrl #(
        .ROWS       (ROWS),
        .RESULT_LAT (LAT),
        .ADDR_W     (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .blk_addr       (blk_addr),
`ifdef FRAC_SEARCH_CTRL_ABORT_EN
        .abort          (abort),
`endif
        .busy           (busy),
        .done           (done),
        .mv_x           (mv_x),
        .mv_y           (mv_y),
        .stall          (stall),
        .filt_rd_en     (filt_rd_en),
        .ref_rd_en      (ref_rd_en),
        .filt_rd_addr   (filt_rd_addr),
        .ref_rd_addr    (ref_rd_addr),
        .filt_rd_data   (filt_rd_data),
        .ref_rd_data    (ref_rd_data),
        .fs_filter_pix  (fs_filter_pix),
        .fs_ref_pix     (fs_ref_pix),
        .fs_input_ready (fs_input_ready),
        .fs_clear       (fs_clear),
        .fs_mvx         (fs_mvx),
        .fs_mvy         (fs_mvy)
    );

    always #5 clk = ~clk;

    // Row memories: content is the address byte replicated.
    always @(posedge clk) begin
        if (filt_rd_en)
            filt_rd_data <= {8{filt_rd_addr}};
        if (ref_rd_en)
            ref_rd_data <= ~{8{ref_rd_addr}};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [63:0] stall_mask;
        logic [63:0] start_mask;
        int          nsearch;
        logic [2:0]  mvx;
        logic [2:0]  mvy;
        int          exp_done;
        int          first_rdy;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] addr_q[$];
    logic [7:0] row_q[$];
    logic [2:0] last_mvx = '0;
    logic [2:0] last_mvy = '0;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_search(input logic [7:0] b);
        for (int k = 0; k < ROWS; k++) begin
            addr_q.push_back(b + 8'(k));
            row_q.push_back(b + 8'(k));
        end
    endtask

    task automatic chk_reset_vals(input logic [2:0] emx,
                                  input logic [2:0] emy);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mv_x", mv_x, emx);
        chk("rst_mv_y", mv_y, emy);
        chk("rst_rd_en", {filt_rd_en, ref_rd_en}, 0);
        chk("rst_filt_addr", filt_rd_addr, 0);
        chk("rst_ref_addr", ref_rd_addr, 0);
        chk("rst_filt_pix", fs_filter_pix, 0);
        chk("rst_ref_pix", fs_ref_pix, 0);
        chk("rst_ready", fs_input_ready, 0);
        chk("rst_clear", fs_clear, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int         done_at, nleft, clr_at;
        bit         rdy_seen, fin;
        logic [7:0] e;
        logic [2:0] em;
        addr_q.delete();
        row_q.delete();
        push_search(v.base);
        nleft    = v.nsearch;
        done_at  = v.exp_done;
        clr_at   = 1;
        rdy_seen = 0;
        fin      = 0;
        for (int rel = 0; rel < 80; rel++) begin
            start    = (rel < 64) ? v.start_mask[rel] : 1'b0;
            stall    = (rel < 64) ? v.stall_mask[rel] : 1'b0;
            blk_addr = v.base;
            fs_mvx   = rel[2:0] ^ v.mvx;
            fs_mvy   = rel[2:0] ^ v.mvy;
            @(negedge clk);
            if (filt_rd_en || ref_rd_en) begin
                chk("ref_rd_en", ref_rd_en, 1);
                chk("filt_rd_en", filt_rd_en, 1);
                if (addr_q.size() == 0) begin
                    chk("extra_read", 1, 0);
                end else begin
                    e = addr_q.pop_front();
                    chk("filt_rd_addr", filt_rd_addr, e);
                    chk("ref_rd_addr", ref_rd_addr, e);
                end
            end
            if (fs_input_ready) begin
                if (!rdy_seen) begin
                    chk("first_ready_cycle", rel, v.first_rdy);
                    rdy_seen = 1;
                end
                if (row_q.size() == 0) begin
                    chk("extra_row", 1, 0);
                end else begin
                    e = row_q.pop_front();
                    chk("fs_filter_pix", fs_filter_pix, {8{e}});
                    chk("fs_ref_pix", fs_ref_pix, ~{8{e}});
                end
            end
            if (fs_clear)
                chk("fs_clear_cycle", rel, clr_at);
            if (rel == done_at - 1 && nleft > 0)
                chk("busy_before_done", busy, 1);
            if (done) begin
                chk("done_cycle", rel, done_at);
                chk("busy_at_done", busy, 0);
                em = 3'(done_at - 1);
                chk("mv_x", mv_x, em ^ v.mvx);
                chk("mv_y", mv_y, em ^ v.mvy);
                last_mvx = em ^ v.mvx;
                last_mvy = em ^ v.mvy;
                chk("rows_left", row_q.size(), 0);
                nleft--;
                if (nleft > 0) begin
                    push_search(v.base);
                    clr_at  = done_at + 1;
                    done_at = done_at + SLEN;
                end else begin
                    fin = 1;
                end
            end
            step();
            if (fin)
                break;
        end
        if (!fin)
            chk("done_timeout", 1, 0);
        start = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_activity",
                {done, fs_clear, filt_rd_en, fs_input_ready}, 0);
            step();
        end
    endtask

    initial begin
        vecs[0] = '{8'h10, 64'h0,    64'h1, 1, 3'd2, 3'd5, 16, 4};
        vecs[1] = '{8'h20, 64'h70,   64'h1, 1, 3'd1, 3'd6, 19, 4};
        vecs[2] = '{8'hFC, 64'h0,    64'h1, 1, 3'd3, 3'd0, 16, 4};
        vecs[3] = '{8'h31, 64'h4,    64'h1, 1, 3'd4, 3'd7, 17, 5};
        vecs[4] = '{8'h48, 64'h3C00, 64'h1, 1, 3'd5, 3'd1, 16, 4};
        vecs[5] = '{8'h55, 64'h3,    64'h1, 1, 3'd6, 3'd2, 16, 4};
        vecs[6] = '{8'h60, 64'h0,    64'h4109, 1, 3'd7, 3'd3, 16, 4};
        vecs[7] = '{8'h70, 64'h0,    64'h1FFFF, 2, 3'd0, 3'd4, 16, 4};

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals(3'd0, 3'd0);
        step();
        reset = 1'b1;
        step();

        foreach (vecs[i])
            run_vec(vecs[i]);

        // Reset while fetching: everything back to reset values at once.
        start    = 1'b1;
        blk_addr = 8'h30;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk_reset_vals(3'd0, 3'd0);
        step();
        reset = 1'b1;
        step();
        run_vec(vecs[0]);

`ifdef FRAC_SEARCH_CTRL_ABORT_EN
        start    = 1'b1;
        blk_addr = 8'h40;
        fs_mvx   = ~last_mvx;
        fs_mvy   = ~last_mvy;
        step();
        start = 1'b0;
        repeat (6) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_clear", fs_clear, 1);
        chk("abort_ready", fs_input_ready, 0);
        step();
        for (int c = 9; c < 24; c++) begin
            @(negedge clk);
            chk("abort_quiet", {done, fs_clear, fs_input_ready, busy}, 0);
            step();
        end
        chk("abort_mv_x", mv_x, last_mvx);
        chk("abort_mv_y", mv_y, last_mvy);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/frac_search_ctrl.md
# frac_search_ctrl

Sequencer for the `frac_search` fractional motion-search datapath. On a start request it:

- clears the datapath;
- fetches the 8 filter/reference pixel rows of one block from two row memories;
- presents the rows to `frac_search` one per cycle with `input_ready`;
- waits a fixed result latency, then captures `mvx`/`mvy` and pulses `done`.

It sits between the encoder's block scheduler and one `frac_search` instance; the top level wires the two together.

## Interface
Parameters:
- ROWS, 8, rows per block
- RESULT_LAT, 4, cycles from last presented row to valid `mvx`/`mvy`
- ADDR_W, 8, row-memory address width

Ports. One clock `clk`; reset `reset` is asynchronous and active-low.
- clk  in  1  clock
- reset  in  1  async, active-low reset
- start  in  1  request one block search; sampled only when idle
- blk_addr  in  ADDR_W  row-memory address of row 0, latched on accepted start
- busy  out  1  search in progress
- done  out  1  one-cycle pulse: `mv_x`/`mv_y` updated
- mv_x, mv_y  out  3 each  last captured motion vector, held until next `done`
- stall  in  1  row memories unavailable this cycle
- filt_rd_en, ref_rd_en  out  1  read strobes (always equal)
- filt_rd_addr, ref_rd_addr  out  ADDR_W  read addresses (always equal)
- filt_rd_data, ref_rd_data  in  64  read data, valid the cycle after the strobe
- fs_filter_pix, fs_ref_pix  out  64  registered row to the datapath
- fs_input_ready  out  1  row valid to the datapath
- fs_clear  out  1  one-cycle synchronous clear to the datapath
- fs_mvx, fs_mvy  in  3 each  datapath result

## Operation
States: IDLE, CLEAR, FETCH, WAIT_RES.
- **IDLE:** start=1 latches `blk_addr`, zeroes the issue and present counters, goes to CLEAR. start=0 stays in IDLE.
- **CLEAR:** `fs_clear`=1 for exactly one cycle, then FETCH.
- **FETCH:**
  - Each cycle with stall=0, assert both `rd_en` signals with addr = base + issue_cnt (mod 2^ADDR_W), then increment issue_cnt.
  - With stall=1, `rd_en`=0 and nothing advances.
  - After issuing row ROWS-1, stop issuing. Stay in FETCH until present_cnt = ROWS.
- **Row presentation:**
  - Data returned for a read issued in cycle N is registered into `fs_*_pix` at the end of cycle N+1.
  - `fs_input_ready`=1 in cycle N+2; present_cnt increments.
  - Rows are never skipped, duplicated or reordered. `fs_input_ready`=0 in any cycle with no new row.
  - `fs_*_pix` hold their last value when not ready.
- **Enter WAIT_RES** the cycle after the last row is presented. Count RESULT_LAT cycles.
  - At the end of the last counted cycle, capture `fs_mvx`/`fs_mvy` into `mv_x`/`mv_y`, register `done`=1 and return to IDLE.
  - `done` is therefore visible in IDLE.
- **`busy`** = (state != IDLE).
- **start handling:**
  - start while busy is ignored and not queued.
  - start in the cycle `done`=1 is accepted.
- **Reset values:** state IDLE; busy 0, done 0, mv_x 0, mv_y 0, both rd_en 0, both rd_addr 0, fs_filter_pix 0, fs_ref_pix 0, fs_input_ready 0, fs_clear 0.
- **Reset mid-operation:** asserting `reset` forces all of the above immediately. The search in flight is lost and no `done` is generated.

## Timing
- With no stall, start sampled high at the end of cycle 0 gives:
  - CLEAR in cycle 1;
  - reads in cycles 2..ROWS+1;
  - `fs_input_ready` in cycles 4..ROWS+3;
  - WAIT_RES in cycles ROWS+4..ROWS+RESULT_LAT+3;
  - `done` in cycle ROWS+RESULT_LAT+4 (16 with defaults).
- Each stall cycle during FETCH that blocks an issue adds exactly one cycle.
- Stall after the last issue has no effect.
- Back-to-back searches: the next CLEAR follows `done` by one cycle.

## Configuration
- **FRAC_SEARCH_CTRL_ABORT_EN**
  - Defined: adds input `abort` (1 bit). abort=1 while busy forces IDLE on the next edge and pulses `fs_clear` for one cycle. Outstanding read data is discarded and `fs_input_ready` is not raised for it. No `done`; `mv_x`/`mv_y` are unchanged. abort wins over `stall`. abort in IDLE has no effect.
  - Not defined: no `abort` port; a search always runs to `done`.

## Structure
- Package `frac_search_pkg` holds:
  - state enum (IDLE, CLEAR, FETCH, WAIT_RES);
  - constants PIX_W=64, MV_W=3, default ROWS=8.
- One natural sub-module, `frac_row_fetch`: issue counter, address generation, stall handling, 1-cycle return pipeline and present counter. It reports last_presented to the FSM.
- The FSM and result capture live in `frac_search_ctrl`.

## Test plan
- **Reset mid-search:** drop `reset` in FETCH cycle 5 -> all outputs at reset values that cycle; restart later completes normally.
- **Basic:** blk_addr=0x10, no stall, memory row k = 0x0101..01*k -> rd_addr 0x10..0x17 in cycles 2..9, `fs_input_ready` cycles 4..11 with rows in order, `done` cycle 16, mv_x/mv_y = fs values sampled cycle 15.
- **Stall:** stall high in cycles 4..6 -> exactly 8 presented rows in order, no duplicates, `done` at cycle 19.
- **Address wrap:** blk_addr=0xFC -> addresses 0xFC,0xFD,0xFE,0xFF,0x00..0x03.
- **Start handling:** start held high through the whole search -> second CLEAR in the cycle after `done`; start pulses during busy ignored.
- **Abort (with FRAC_SEARCH_CTRL_ABORT_EN):** abort in cycle 7 -> busy=0 in cycle 8, one `fs_clear` pulse, no `done`, mv_x/mv_y unchanged.
